// File: rtl/bram_rd_pkg.sv
// Shared constants, FSM encoding and word-index helper for the BRAM read responder.
package bram_rd_pkg;
  localparam int ADDR_W         = 13;
  localparam int LINE_ADDR_W    = 9;
  localparam int WORD_W         = 32;
  localparam int LINE_W         = 512;
  localparam int WORDS_PER_LINE = 16;
  localparam int IDX_W          = 4;
  localparam int CNT_W          = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_VALID = 2'd3;

  // Word accesses pick the addressed word; line accesses report word 0.
  function automatic logic [IDX_W-1:0] word_idx(input logic acc32, input logic [ADDR_W-1:0] addr);
    return acc32 ? addr[IDX_W-1:0] : '0;
  endfunction
endpackage

// File: rtl/bram_rd_responder_word_sel.sv
// 16:1 combinational word multiplexer over a 512-bit line.
module bram_word_sel
  import bram_rd_pkg::*;
(
  input  logic [LINE_W-1:0] line_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic [WORD_W-1:0] word_o
);
  assign word_o = line_i[idx_i*WORD_W +: WORD_W];
endmodule

// File: rtl/bram_rd_responder.sv
// BRAM read responder: accepts a level-handshake read, issues one BRAM enable,
// waits RD_LATENCY cycles, then holds line/word data valid until ready drops.
module bram_rd_responder
  import bram_rd_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_bram_access_type,
  input  logic [ADDR_W-1:0]      i_bram_rd_addr,
  input  logic                   i_bram_rd_addr_ready,
  output logic                   o_bram_data_valid,
  output logic [WORD_W-1:0]      o_bram_data,
  output logic [LINE_W-1:0]      o_bram_line,
  output logic                   o_mem_en,
  output logic [LINE_ADDR_W-1:0] o_mem_addr,
  input  logic [LINE_W-1:0]      i_mem_dout,
  output logic                   o_busy
);
  logic [1:0]        state_q, state_d;
  logic              type_q, type_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [WORD_W-1:0] sel_word;

  bram_word_sel u_word_sel (
    .line_i (i_mem_dout),
    .idx_i  (word_idx(type_q, addr_q)),
    .word_o (sel_word)
  );

  // Next-state logic; ready low in any busy state returns to IDLE and drops pending data.
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    data_d  = data_q;
    line_d  = line_q;
    case (state_q)
      ST_IDLE: begin
        if (i_bram_rd_addr_ready) begin
          type_d  = i_bram_access_type;
          addr_d  = i_bram_rd_addr;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!i_bram_rd_addr_ready) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = CNT_W'(RD_LATENCY);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (!i_bram_rd_addr_ready) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          line_d  = i_mem_dout;
          data_d  = sel_word;
          valid_d = 1'b1;
          state_d = ST_VALID;
        end
      end
      default: begin
        if (!i_bram_rd_addr_ready) begin
          valid_d = 1'b0;
          data_d  = '0;
          line_d  = '0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      type_q  <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      line_q  <= line_d;
    end
  end

  assign o_mem_en          = (state_q == ST_ISSUE);
  assign o_mem_addr        = o_mem_en ? addr_q[ADDR_W-1 -: LINE_ADDR_W] : '0;
  assign o_busy            = (state_q != ST_IDLE);
  assign o_bram_data_valid = valid_q;
  assign o_bram_data       = data_q;
  assign o_bram_line       = line_q;
endmodule

// File: tb/tb_bram_rd_responder.sv
// Directed bench: four responders (RD_LATENCY 1..4), each with its own BRAM model.
module tb_bram_rd_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rdy = '0;
  logic [3:0]  typ = '0;
  logic [12:0] addr [4];
  logic [3:0]  vld, en, busy;
  logic [31:0] data [4];
  logic [511:0] line [4];
  logic [511:0] dout [4];
  logic [8:0]  maddr [4];
  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [8:0] l, input int k);
    logic [3:0] k4;
    k4 = 4'(k);
    return (l == 9'h005) ? 32'hA000_0000 + 32'(k) : {3'b000, l, 16'h0000, k4};
  endfunction

  function automatic logic [511:0] line_of(input logic [8:0] l);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = word_of(l, k);
    return r;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : gi
    logic [8:0] apipe [0:g];
    always @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i <= g; i++) apipe[i] <= '0;
      end else begin
        apipe[0] <= en[g] ? maddr[g] : 9'h000;
        for (int i = 1; i <= g; i++) apipe[i] <= apipe[i-1];
      end
    end
    assign dout[g] = line_of(apipe[g]);

    bram_rd_responder #(.RD_LATENCY(g + 1)) dut (
      .i_clk                (clk),
      .i_rst                (rst),
      .i_bram_access_type   (typ[g]),
      .i_bram_rd_addr       (addr[g]),
      .i_bram_rd_addr_ready (rdy[g]),
      .o_bram_data_valid    (vld[g]),
      .o_bram_data          (data[g]),
      .o_bram_line          (line[g]),
      .o_mem_en             (en[g]),
      .o_mem_addr           (maddr[g]),
      .i_mem_dout           (dout[g]),
      .o_busy               (busy[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_until(input int g, output int n, output int ens);
    n = 0;
    ens = 0;
    repeat (20) begin
      tick();
      n++;
      if (en[g]) ens++;
      if (vld[g]) break;
    end
  endtask

  initial begin
    int n, e;
    for (int i = 0; i < 4; i++) addr[i] = '0;

    // Reset state
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      chk("rst_vld", 512'(vld[i]), 512'(0));
      chk("rst_busy", 512'(busy[i]), 512'(0));
      chk("rst_en", 512'(en[i]), 512'(0));
      chk("rst_data", 512'(data[i]), 512'(0));
      chk("rst_line", line[i], 512'(0));
    end
    rst = 1'b0;
    tick();

    // 32-bit read, latency 1
    typ[0] = 1'b1; addr[0] = 13'h0053; rdy[0] = 1'b1;
    tick();
    chk("w32_en", 512'(en[0]), 512'(1));
    chk("w32_maddr", 512'(maddr[0]), 512'h005);
    chk("w32_busy", 512'(busy[0]), 512'(1));
    chk("w32_vld_c1", 512'(vld[0]), 512'(0));
    tick();
    chk("w32_en_c2", 512'(en[0]), 512'(0));
    chk("w32_vld_c2", 512'(vld[0]), 512'(0));
    tick();
    chk("w32_vld_c3", 512'(vld[0]), 512'(1));
    chk("w32_data", 512'(data[0]), 512'h A000_0003);
    chk("w32_line", line[0], line_of(9'h005));

    // Hold with address/type toggling
    for (int i = 0; i < 10; i++) begin
      addr[0] = addr[0] ^ 13'h1FFF;
      typ[0] = ~typ[0];
      tick();
      chk("hold_vld", 512'(vld[0]), 512'(1));
      chk("hold_data", 512'(data[0]), 512'h A000_0003);
    end
    rdy[0] = 1'b0;
    tick();
    chk("rel_vld", 512'(vld[0]), 512'(0));
    chk("rel_busy", 512'(busy[0]), 512'(0));
    chk("rel_data", 512'(data[0]), 512'(0));
    chk("rel_line", line[0], 512'(0));

    // 512-bit read, issued in the cycle right after VALID exit
    typ[0] = 1'b0; addr[0] = 13'h1FFF; rdy[0] = 1'b1;
    tick();
    chk("l512_en", 512'(en[0]), 512'(1));
    chk("l512_maddr", 512'(maddr[0]), 512'h1FF);
    tick(); tick();
    chk("l512_vld", 512'(vld[0]), 512'(1));
    chk("l512_line", line[0], line_of(9'h1FF));
    chk("l512_data", 512'(data[0]), 512'h1FF0_0000);
    rdy[0] = 1'b0;
    tick();
    chk("l512_rel", 512'(vld[0]), 512'(0));

    // Abort in WAIT, latency 4
    typ[3] = 1'b1; addr[3] = 13'h0053; rdy[3] = 1'b1;
    tick(); tick(); tick();
    rdy[3] = 1'b0;
    tick();
    chk("abort_busy", 512'(busy[3]), 512'(0));
    chk("abort_vld", 512'(vld[3]), 512'(0));
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_novld", 512'(vld[3]), 512'(0));
    end
    addr[3] = 13'h0010; rdy[3] = 1'b1;
    run_until(3, n, e);
    chk("abort_next_lat", 512'(n), 512'(6));
    chk("abort_next_en", 512'(e), 512'(1));
    chk("abort_next_data", 512'(data[3]), 512'h0010_0000);
    rdy[3] = 1'b0;
    tick();

    // Reset mid-WAIT
    addr[3] = 13'h0053; rdy[3] = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1; rdy[3] = 1'b0;
    tick();
    chk("mrst_vld", 512'(vld[3]), 512'(0));
    chk("mrst_busy", 512'(busy[3]), 512'(0));
    chk("mrst_en", 512'(en[3]), 512'(0));
    chk("mrst_maddr", 512'(maddr[3]), 512'(0));
    chk("mrst_data", 512'(data[3]), 512'(0));
    chk("mrst_line", line[3], 512'(0));
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mrst_novld", 512'(vld[3]), 512'(0));
    end
    rdy[3] = 1'b1;
    run_until(3, n, e);
    chk("mrst_next_lat", 512'(n), 512'(6));
    chk("mrst_next_data", 512'(data[3]), 512'h A000_0003);
    rdy[3] = 1'b0;
    tick();

    // Latency sweep
    for (int g = 0; g < 4; g++) begin
      typ[g] = 1'b1; addr[g] = 13'h0053; rdy[g] = 1'b1;
      run_until(g, n, e);
      chk("sweep_lat", 512'(n), 512'(g + 3));
      chk("sweep_en", 512'(e), 512'(1));
      chk("sweep_data", 512'(data[g]), 512'h A000_0003);
      rdy[g] = 1'b0;
      tick();
      chk("sweep_rel", 512'(vld[g]), 512'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
